pipe_stage_buffer: RTL and testbench
====================================

Name: pipe_stage_buffer

Overview:
- Parametrised successor to the fixed decode-to-execute pipeline register.
- Chains STAGES elastic stages, each with a valid/ready handshake and a 2-entry skid buffer.
- Adds synchronous flush (bubble insertion), back-pressure and an occupancy count.
- Sits between any two processor pipeline stages. Separate CTRL and DATA buses allow a flush to zero the control fields while optionally keeping the data fields.

Parameters:
- DATA_WIDTH, 32, width of the data payload bus.
- CTRL_WIDTH, 16, width of the control payload bus (RegWrite, MemWrite, ALUControl, …, concatenated).
- STAGES, 1, number of chained elastic stages (≥1).
- CLR_DATA, 1, 1: flush also zeroes data registers; 0: data registers hold their contents on flush.
- CNT_WIDTH, $clog2(2*STAGES+1), width of the occupancy count (derived; do not override).

Ports:
- i_CLK  in  1  clock, rising edge.
- i_RST  in  1  asynchronous active-low reset.
- i_CLR  in  1  synchronous flush; empties every stage.
- i_ValidD  in  1  upstream item valid.
- o_ReadyD  out  1  buffer can accept an item.
- i_DataD  in  DATA_WIDTH  upstream data payload.
- i_CtrlD  in  CTRL_WIDTH  upstream control payload.
- o_ValidE  out  1  downstream item valid.
- i_ReadyE  in  1  downstream accepts the item.
- o_DataE  out  DATA_WIDTH  downstream data payload.
- o_CtrlE  out  CTRL_WIDTH  downstream control; forced to 0 whenever o_ValidE=0.
- o_Count  out  CNT_WIDTH  number of valid entries held (0..2*STAGES).
- o_Empty  out  1  o_Count==0.
- o_Full  out  1  o_Count==2*STAGES.

Behaviour:
- Clock and reset: one clock, i_CLK. Reset i_RST is asynchronous, active-low.
- Reset: all valid bits, skid bits, data and control registers go to 0. Then o_ValidE=0, o_ReadyD=1, o_Count=0, o_Empty=1, o_Full=0, o_DataE=0, o_CtrlE=0. A reset asserted mid-transfer discards all in-flight items immediately.
- Transfers: an upstream transfer occurs when i_ValidD & o_ReadyD. A downstream transfer occurs when o_ValidE & i_ReadyE.
- Per stage cell: one main register and one skid register, each with a valid bit.
  - cell ready = ~skid_valid. This is a registered value, so there is no combinational path from ready-out to ready-in.
  - Output side: the cell presents the main entry. When it is accepted, main takes the skid entry if skid_valid, otherwise the incoming item, otherwise it goes empty.
  - Incoming item with main valid, main not being accepted, and skid empty: the item goes into skid.
- Latency: 1 cycle per stage, so an item presented at cycle n appears at o_ValidE at cycle n+STAGES when unblocked. Throughput is 1 item/cycle.
- Back-pressure: while o_ValidE=1 and i_ReadyE=0, o_DataE and o_CtrlE hold stable and o_ValidE must not drop (except on i_CLR or reset).
- Full: each stage fills in turn. o_ReadyD falls the cycle after the first-stage skid fills. Total capacity is 2*STAGES items.
- Flush (i_CLR=1 at edge):
  - All valid and skid bits clear and all control registers are 0 next cycle. Data registers are 0 if CLR_DATA=1, else held.
  - An upstream item offered in the same cycle is discarded, even though o_ReadyD may read 1.
  - A downstream transfer in the same cycle still counts as consumed by the receiver.
  - i_CLR has priority over every transfer.
- Occupancy: o_Count is a registered sum. It is updated by +1 (in only), −1 (out only), 0 (both or neither), or forced to 0 (i_CLR). No overflow is possible because o_ReadyD gates input. o_Empty and o_Full are derived combinationally from o_Count.
- Illegal use (i_ValidD dropped before acceptance) is the upstream's problem. The buffer takes no special action.

Decomposition:
- Shared package (pipe_pkg): handshake state constants, the clog2 helper, and the standard CTRL field offsets for the decode→execute control bundle so stage instances agree on packing.
- One sub-module, pipe_stage_cell: one elastic stage with main and skid registers and the CLR/CLR_DATA handling. The top instantiates STAGES of them through a generate loop and adds the occupancy counter and the o_CtrlE gating.

Test Plan:
- Reset/idle: assert i_RST=0 mid-stream with 3 items held (STAGES=2) → next sample o_ValidE=0, o_Count=0, o_ReadyD=1, o_DataE=0.
- Streaming: STAGES=2, i_ReadyE=1, push 0xA0..0xA7 back-to-back → each appears 2 cycles later in order, one per cycle, o_Count steady at 2.
- Back-pressure to full: STAGES=2, i_ReadyE=0, push 0x11,0x22,0x33,0x44,0x55 → first 4 accepted, o_Full=1, o_ReadyD=0, 0x55 held upstream. Release i_ReadyE → output 0x11,0x22,0x33,0x44,0x55 with no loss or duplication.
- Flush with simultaneous input: 3 items held, i_CLR=1 while i_ValidD=1 with 0x99 → next cycle o_Count=0, o_ValidE=0, o_CtrlE=0, and 0x99 never appears.
- CLR_DATA=0: flush with o_DataE=0xDEADBEEF, i_ReadyE=0 → o_ValidE=0, o_CtrlE=0, internal data still 0xDEADBEEF; next valid item overwrites it normally.
- Stall stability: o_ValidE=1 with CTRL=0x00A5, hold i_ReadyE=0 for 10 cycles → o_CtrlE, o_DataE and o_ValidE unchanged every cycle, o_Count constant.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline buffer and its stage cells.
// Holds the per-cell occupancy state encoding, a constant clog2 helper and
// the standard bit offsets of the decode-to-execute control bundle.
package pipe_pkg;

    // Occupancy of one cell, encoded as {skid_valid, main_valid}.
    // A skid-only state cannot occur: skid fills only behind a held main entry.
    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_MAIN  = 2'b01,
        CELL_BOTH  = 2'b11
    } cell_state_e;

    // Packing of the decode->execute control bundle on the CTRL bus.
    localparam int CTRL_REGWRITE_BIT  = 0;
    localparam int CTRL_MEMWRITE_BIT  = 1;
    localparam int CTRL_MEMTOREG_BIT  = 2;
    localparam int CTRL_BRANCH_BIT    = 3;
    localparam int CTRL_JUMP_BIT      = 4;
    localparam int CTRL_ALUSRC_BIT    = 5;
    localparam int CTRL_ALUCTRL_LSB   = 6;
    localparam int CTRL_ALUCTRL_WIDTH = 4;
    localparam int CTRL_RESULTSRC_LSB = 10;
    localparam int CTRL_RESULTSRC_W   = 2;

    // Constant-evaluable ceil(log2(value)); returns 0 for value <= 1.
    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_stage_cell.sv
// One elastic stage: main register plus 2-entry skid, valid/ready on both sides.
// Latency 1 cycle; throughput 1 item/cycle.
// Back-pressure: in_rdy_o is the registered inverse of skid valid, so no comb ready path.
//
// Ports: clk_i/rst_ni clock and async active-low reset; clr_i synchronous flush;
//        in_*  upstream valid/ready/data/ctrl; out_* downstream valid/ready/data/ctrl.
module pipe_stage_cell
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 16,
    parameter bit CLR_DATA   = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  in_vld_i,
    output logic                  in_rdy_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic [CTRL_WIDTH-1:0] in_ctrl_i,
    output logic                  out_vld_o,
    input  logic                  out_rdy_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [CTRL_WIDTH-1:0] out_ctrl_o
);

    logic                  m_vld_q, m_vld_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [CTRL_WIDTH-1:0] m_ctrl_q, m_ctrl_d;
    logic                  s_vld_q, s_vld_d;
    logic [DATA_WIDTH-1:0] s_data_q, s_data_d;
    logic [CTRL_WIDTH-1:0] s_ctrl_q, s_ctrl_d;

    cell_state_e state;
    logic        in_fire;
    logic        out_fire;

    assign in_rdy_o   = ~s_vld_q;
    assign out_vld_o  = m_vld_q;
    assign out_data_o = m_data_q;
    assign out_ctrl_o = m_ctrl_q;

    always_comb begin
        m_vld_d  = m_vld_q;
        m_data_d = m_data_q;
        m_ctrl_d = m_ctrl_q;
        s_vld_d  = s_vld_q;
        s_data_d = s_data_q;
        s_ctrl_d = s_ctrl_q;

        state    = s_vld_q ? CELL_BOTH : (m_vld_q ? CELL_MAIN : CELL_EMPTY);
        in_fire  = in_vld_i & ~s_vld_q;
        out_fire = m_vld_q & out_rdy_i;

        if (clr_i) begin
            // Flush wins over any transfer; data optionally survives.
            m_vld_d  = 1'b0;
            s_vld_d  = 1'b0;
            m_ctrl_d = '0;
            s_ctrl_d = '0;
            if (CLR_DATA) begin
                m_data_d = '0;
                s_data_d = '0;
            end
        end else begin
            unique case (state)
                CELL_EMPTY: begin
                    if (in_fire) begin
                        m_vld_d  = 1'b1;
                        m_data_d = in_data_i;
                        m_ctrl_d = in_ctrl_i;
                    end
                end
                CELL_MAIN: begin
                    if (out_fire) begin
                        m_vld_d  = in_fire;
                        if (in_fire) begin
                            m_data_d = in_data_i;
                            m_ctrl_d = in_ctrl_i;
                        end
                    end else if (in_fire) begin
                        // Main is stalled: park the new item in the skid slot.
                        s_vld_d  = 1'b1;
                        s_data_d = in_data_i;
                        s_ctrl_d = in_ctrl_i;
                    end
                end
                CELL_BOTH: begin
                    // No input possible here (ready is low); drain skid into main.
                    if (out_fire) begin
                        m_data_d = s_data_q;
                        m_ctrl_d = s_ctrl_q;
                        s_vld_d  = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_vld_q  <= 1'b0;
            m_data_q <= '0;
            m_ctrl_q <= '0;
            s_vld_q  <= 1'b0;
            s_data_q <= '0;
            s_ctrl_q <= '0;
        end else begin
            m_vld_q  <= m_vld_d;
            m_data_q <= m_data_d;
            m_ctrl_q <= m_ctrl_d;
            s_vld_q  <= s_vld_d;
            s_data_q <= s_data_d;
            s_ctrl_q <= s_ctrl_d;
        end
    end

endmodule

// File: rtl/pipe_stage_buffer.sv
// Chain of STAGES elastic cells between two pipeline stages, with flush and occupancy count.
// Latency STAGES cycles when unblocked; throughput 1 item/cycle; capacity 2*STAGES items.
// Back-pressure: i_ReadyE low holds o_ValidE/o_DataE/o_CtrlE; o_ReadyD falls once stage 0 skid fills.
//
// Ports: i_CLK clock; i_RST async active-low reset; i_CLR synchronous flush;
//        i_ValidD/o_ReadyD/i_DataD/i_CtrlD upstream side; o_ValidE/i_ReadyE/o_DataE/o_CtrlE downstream;
//        o_Count/o_Empty/o_Full occupancy.
module pipe_stage_buffer
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 16,
    parameter int STAGES     = 1,
    parameter bit CLR_DATA   = 1'b1,
    parameter int CNT_WIDTH  = clog2_f(2*STAGES+1)
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_CLR,
    input  logic                  i_ValidD,
    output logic                  o_ReadyD,
    input  logic [DATA_WIDTH-1:0] i_DataD,
    input  logic [CTRL_WIDTH-1:0] i_CtrlD,
    output logic                  o_ValidE,
    input  logic                  i_ReadyE,
    output logic [DATA_WIDTH-1:0] o_DataE,
    output logic [CTRL_WIDTH-1:0] o_CtrlE,
    output logic [CNT_WIDTH-1:0]  o_Count,
    output logic                  o_Empty,
    output logic                  o_Full
);

    // Index k is the link feeding cell k; index STAGES is the output link.
    logic                  vld_w  [0:STAGES];
    logic                  rdy_w  [0:STAGES];
    logic [DATA_WIDTH-1:0] data_w [0:STAGES];
    logic [CTRL_WIDTH-1:0] ctrl_w [0:STAGES];

    assign vld_w[0]       = i_ValidD;
    assign data_w[0]      = i_DataD;
    assign ctrl_w[0]      = i_CtrlD;
    assign rdy_w[STAGES]  = i_ReadyE;
    assign o_ReadyD       = rdy_w[0];

    for (genvar g = 0; g < STAGES; g++) begin : g_cell
        pipe_stage_cell #(
            .DATA_WIDTH (DATA_WIDTH),
            .CTRL_WIDTH (CTRL_WIDTH),
            .CLR_DATA   (CLR_DATA)
        ) u_cell (
            .clk_i      (i_CLK),
            .rst_ni     (i_RST),
            .clr_i      (i_CLR),
            .in_vld_i   (vld_w[g]),
            .in_rdy_o   (rdy_w[g]),
            .in_data_i  (data_w[g]),
            .in_ctrl_i  (ctrl_w[g]),
            .out_vld_o  (vld_w[g+1]),
            .out_rdy_i  (rdy_w[g+1]),
            .out_data_o (data_w[g+1]),
            .out_ctrl_o (ctrl_w[g+1])
        );
    end

    assign o_ValidE = vld_w[STAGES];
    assign o_DataE  = data_w[STAGES];
    // Control fields must never leak out with an invalid slot.
    assign o_CtrlE  = ctrl_w[STAGES] & {CTRL_WIDTH{vld_w[STAGES]}};

    logic                 up_fire;
    logic                 dn_fire;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    assign up_fire = i_ValidD & o_ReadyD;
    assign dn_fire = o_ValidE & i_ReadyE;

    always_comb begin
        count_d = count_q;
        if (i_CLR) begin
            count_d = '0;
        end else if (up_fire && !dn_fire) begin
            count_d = count_q + CNT_WIDTH'(1);
        end else if (!up_fire && dn_fire) begin
            count_d = count_q - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_Count = count_q;
    assign o_Empty = (count_q == '0);
    assign o_Full  = (count_q == CNT_WIDTH'(2*STAGES));

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed bench for pipe_stage_buffer: a STAGES=2 flushing instance and a
// STAGES=1 instance that keeps data on flush.
module tb_pipe_stage_buffer;

    logic        clk;
    logic        rst_n;

    // STAGES=2, CLR_DATA=1 instance
    logic        clr, vld_d, rdy_e;
    logic [31:0] data_d;
    logic [15:0] ctrl_d;
    logic        rdy_d, vld_e, empty, full;
    logic [31:0] data_e;
    logic [15:0] ctrl_e;
    logic [2:0]  cnt;

    // STAGES=1, CLR_DATA=0 instance
    logic        n_clr, n_vld, n_rdy_e;
    logic [31:0] n_data;
    logic [15:0] n_ctrl;
    logic        n_rdy_d, n_vld_e, n_empty, n_full;
    logic [31:0] n_data_e;
    logic [15:0] n_ctrl_e;
    logic [1:0]  n_cnt;

    int checks = 0;
    int errors = 0;

    pipe_stage_buffer #(.DATA_WIDTH(32), .CTRL_WIDTH(16), .STAGES(2), .CLR_DATA(1'b1)) dut (
        .i_CLK(clk), .i_RST(rst_n), .i_CLR(clr),
        .i_ValidD(vld_d), .o_ReadyD(rdy_d), .i_DataD(data_d), .i_CtrlD(ctrl_d),
        .o_ValidE(vld_e), .i_ReadyE(rdy_e), .o_DataE(data_e), .o_CtrlE(ctrl_e),
        .o_Count(cnt), .o_Empty(empty), .o_Full(full)
    );

    pipe_stage_buffer #(.DATA_WIDTH(32), .CTRL_WIDTH(16), .STAGES(1), .CLR_DATA(1'b0)) dut_nc (
        .i_CLK(clk), .i_RST(rst_n), .i_CLR(n_clr),
        .i_ValidD(n_vld), .o_ReadyD(n_rdy_d), .i_DataD(n_data), .i_CtrlD(n_ctrl),
        .o_ValidE(n_vld_e), .i_ReadyE(n_rdy_e), .o_DataE(n_data_e), .o_CtrlE(n_ctrl_e),
        .o_Count(n_cnt), .o_Empty(n_empty), .o_Full(n_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        vld;
        logic [31:0] dat;
        logic        rdye;
        logic        exp_vld;
        logic [31:0] exp_dat;
        logic        exp_rdy;
        int          exp_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, input logic [31:0] d, input logic re,
                                input logic ev, input logic [31:0] ed, input logic er, input int ec);
        vec_t t;
        t.vld = v; t.dat = d; t.rdye = re;
        t.exp_vld = ev; t.exp_dat = ed; t.exp_rdy = er; t.exp_cnt = ec;
        return t;
    endfunction

    // Control payload tied to data so ordering errors show on both buses.
    function automatic logic [15:0] ctrl_of(input logic [31:0] d);
        return {8'hC0, d[7:0]};
    endfunction

    initial begin
        logic [15:0] exp_ctrl;

        rst_n = 1'b0;
        clr = 1'b0; vld_d = 1'b0; rdy_e = 1'b0; data_d = '0; ctrl_d = '0;
        n_clr = 1'b0; n_vld = 1'b0; n_rdy_e = 1'b0; n_data = '0; n_ctrl = '0;

        // Streaming, STAGES=2, downstream always ready: 2-cycle latency, count 2.
        vecs.push_back(mk(1'b1, 32'hA0, 1'b1, 1'b0, 32'h00, 1'b1, 1));
        vecs.push_back(mk(1'b1, 32'hA1, 1'b1, 1'b1, 32'hA0, 1'b1, 2));
        vecs.push_back(mk(1'b1, 32'hA2, 1'b1, 1'b1, 32'hA1, 1'b1, 2));
        vecs.push_back(mk(1'b1, 32'hA3, 1'b1, 1'b1, 32'hA2, 1'b1, 2));
        vecs.push_back(mk(1'b1, 32'hA4, 1'b1, 1'b1, 32'hA3, 1'b1, 2));
        vecs.push_back(mk(1'b1, 32'hA5, 1'b1, 1'b1, 32'hA4, 1'b1, 2));
        vecs.push_back(mk(1'b1, 32'hA6, 1'b1, 1'b1, 32'hA5, 1'b1, 2));
        vecs.push_back(mk(1'b1, 32'hA7, 1'b1, 1'b1, 32'hA6, 1'b1, 2));
        vecs.push_back(mk(1'b0, 32'h00, 1'b1, 1'b1, 32'hA7, 1'b1, 1));
        vecs.push_back(mk(1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1'b1, 0));
        // Fill to capacity with downstream stalled; 0x55 waits upstream.
        vecs.push_back(mk(1'b1, 32'h11, 1'b0, 1'b0, 32'h00, 1'b1, 1));
        vecs.push_back(mk(1'b1, 32'h22, 1'b0, 1'b1, 32'h11, 1'b1, 2));
        vecs.push_back(mk(1'b1, 32'h33, 1'b0, 1'b1, 32'h11, 1'b1, 3));
        vecs.push_back(mk(1'b1, 32'h44, 1'b0, 1'b1, 32'h11, 1'b0, 4));
        vecs.push_back(mk(1'b1, 32'h55, 1'b0, 1'b1, 32'h11, 1'b0, 4));
        // Release: drain in order, 0x55 accepted once ready returns.
        vecs.push_back(mk(1'b1, 32'h55, 1'b1, 1'b1, 32'h22, 1'b0, 3));
        vecs.push_back(mk(1'b1, 32'h55, 1'b1, 1'b1, 32'h33, 1'b1, 2));
        vecs.push_back(mk(1'b1, 32'h55, 1'b1, 1'b1, 32'h44, 1'b1, 2));
        vecs.push_back(mk(1'b0, 32'h00, 1'b1, 1'b1, 32'h55, 1'b1, 1));
        vecs.push_back(mk(1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1'b1, 0));

        // Reset state
        #2;
        chk("rst_valid", {31'b0, vld_e}, 32'd0);
        chk("rst_ready", {31'b0, rdy_d}, 32'd1);
        chk("rst_count", {29'b0, cnt}, 32'd0);
        chk("rst_empty", {31'b0, empty}, 32'd1);
        chk("rst_full", {31'b0, full}, 32'd0);
        chk("rst_data", data_e, 32'd0);
        chk("rst_ctrl", {16'b0, ctrl_e}, 32'd0);
        chk("rst_nc_count", {30'b0, n_cnt}, 32'd0);
        #1 rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            vld_d  = vecs[i].vld;
            data_d = vecs[i].dat;
            ctrl_d = ctrl_of(vecs[i].dat);
            rdy_e  = vecs[i].rdye;
            tick();
            exp_ctrl = vecs[i].exp_vld ? ctrl_of(vecs[i].exp_dat) : 16'h0000;
            chk($sformatf("vec%0d_valid", i), {31'b0, vld_e}, {31'b0, vecs[i].exp_vld});
            if (vecs[i].exp_vld)
                chk($sformatf("vec%0d_data", i), data_e, vecs[i].exp_dat);
            chk($sformatf("vec%0d_ctrl", i), {16'b0, ctrl_e}, {16'b0, exp_ctrl});
            chk($sformatf("vec%0d_ready", i), {31'b0, rdy_d}, {31'b0, vecs[i].exp_rdy});
            chk($sformatf("vec%0d_count", i), {29'b0, cnt}, vecs[i].exp_cnt);
            chk($sformatf("vec%0d_empty", i), {31'b0, empty}, {31'b0, (vecs[i].exp_cnt == 0)});
            chk($sformatf("vec%0d_full", i), {31'b0, full}, {31'b0, (vecs[i].exp_cnt == 4)});
        end

        // Stall stability: one item parked at the output for 10 cycles.
        vld_d = 1'b1; data_d = 32'h1234_5678; ctrl_d = 16'h00A5; rdy_e = 1'b0;
        tick();
        vld_d = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("stall%0d_valid", i), {31'b0, vld_e}, 32'd1);
            chk($sformatf("stall%0d_data", i), data_e, 32'h1234_5678);
            chk($sformatf("stall%0d_ctrl", i), {16'b0, ctrl_e}, 32'h0000_00A5);
            chk($sformatf("stall%0d_count", i), {29'b0, cnt}, 32'd1);
        end

        // Two more items to hold 3, then flush with an item offered in the same cycle.
        vld_d = 1'b1; data_d = 32'hB1; ctrl_d = 16'h00B1;
        tick();
        data_d = 32'hB2; ctrl_d = 16'h00B2;
        tick();
        chk("preflush_count", {29'b0, cnt}, 32'd3);
        clr = 1'b1; vld_d = 1'b1; data_d = 32'h99; ctrl_d = 16'h0099;
        tick();
        chk("flush_count", {29'b0, cnt}, 32'd0);
        chk("flush_valid", {31'b0, vld_e}, 32'd0);
        chk("flush_ctrl", {16'b0, ctrl_e}, 32'd0);
        chk("flush_data", data_e, 32'd0);
        chk("flush_ready", {31'b0, rdy_d}, 32'd1);
        chk("flush_empty", {31'b0, empty}, 32'd1);
        clr = 1'b0; vld_d = 1'b0; rdy_e = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("postflush%0d_valid", i), {31'b0, vld_e}, 32'd0);
            chk($sformatf("postflush%0d_count", i), {29'b0, cnt}, 32'd0);
        end

        // Flush that keeps data (STAGES=1, CLR_DATA=0).
        n_vld = 1'b1; n_data = 32'hDEAD_BEEF; n_ctrl = 16'h0F0F; n_rdy_e = 1'b0;
        tick();
        n_vld = 1'b0;
        chk("nc_load_valid", {31'b0, n_vld_e}, 32'd1);
        chk("nc_load_data", n_data_e, 32'hDEAD_BEEF);
        chk("nc_full", {31'b0, n_full}, 32'd0);
        n_clr = 1'b1;
        tick();
        n_clr = 1'b0;
        chk("nc_flush_valid", {31'b0, n_vld_e}, 32'd0);
        chk("nc_flush_ctrl", {16'b0, n_ctrl_e}, 32'd0);
        chk("nc_flush_data", n_data_e, 32'hDEAD_BEEF);
        chk("nc_flush_count", {30'b0, n_cnt}, 32'd0);
        n_vld = 1'b1; n_data = 32'h0BAD_F00D; n_ctrl = 16'h0011;
        tick();
        n_vld = 1'b0; n_rdy_e = 1'b1;
        chk("nc_next_valid", {31'b0, n_vld_e}, 32'd1);
        chk("nc_next_data", n_data_e, 32'h0BAD_F00D);
        chk("nc_next_ctrl", {16'b0, n_ctrl_e}, 32'h0000_0011);
        tick();
        chk("nc_drain_valid", {31'b0, n_vld_e}, 32'd0);
        chk("nc_drain_empty", {31'b0, n_empty}, 32'd1);

        // Asynchronous reset mid-stream with 3 items held.
        rdy_e = 1'b0; vld_d = 1'b1;
        data_d = 32'hC1; ctrl_d = 16'h00C1; tick();
        data_d = 32'hC2; ctrl_d = 16'h00C2; tick();
        data_d = 32'hC3; ctrl_d = 16'h00C3; tick();
        chk("prereset_count", {29'b0, cnt}, 32'd3);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'b0, vld_e}, 32'd0);
        chk("midrst_count", {29'b0, cnt}, 32'd0);
        chk("midrst_ready", {31'b0, rdy_d}, 32'd1);
        chk("midrst_data", data_e, 32'd0);
        chk("midrst_ctrl", {16'b0, ctrl_e}, 32'd0);
        vld_d = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        chk("afterrst_count", {29'b0, cnt}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
